if_fetch_stage: RTL

IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

---
 rtl/if_fetch_if.sv | 28 ++
 rtl/if_fetch_stage.sv | 119 +++++++++++
 2 files changed

// File: rtl/if_fetch_if.sv
// if_fetch_if: fetch-stage control, redirect, instruction-memory and IF/ID signal bundle
interface if_fetch_if;
  logic        PC_Stall;
  logic        IF_ID_Stall;
  logic        IF_ID_Flush;
  logic [1:0]  PCSrc;
  logic [31:0] Branch_Target;
  logic [25:0] Jump_Index;
  logic [31:0] JR_Target;
  logic        IMem_Req;
  logic [31:0] IMem_Addr;
  logic        IMem_Ready;
  logic [31:0] IMem_Data;
  logic [31:0] IF_ID_Instr;
  logic [31:0] IF_ID_PC4;
  logic        IF_ID_Valid;
  logic        Fetch_Busy;
  modport master (
    input  PC_Stall, IF_ID_Stall, IF_ID_Flush, PCSrc, Branch_Target, Jump_Index, JR_Target,
    input  IMem_Ready, IMem_Data,
    output IMem_Req, IMem_Addr, IF_ID_Instr, IF_ID_PC4, IF_ID_Valid, Fetch_Busy
  );
  modport slave (
    output PC_Stall, IF_ID_Stall, IF_ID_Flush, PCSrc, Branch_Target, Jump_Index, JR_Target,
    output IMem_Ready, IMem_Data,
    input  IMem_Req, IMem_Addr, IF_ID_Instr, IF_ID_PC4, IF_ID_Valid, Fetch_Busy
  );
endinterface

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC/fetch FSM feeding the IF/ID register with redirect and response buffering
// IF_FETCH_PERF_EN adds Stall_Cycles/Flush_Count counter outputs.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef IF_FETCH_PERF_EN
  output logic [31:0] Stall_Cycles,
  output logic [31:0] Flush_Count,
`endif
  if_fetch_if.master  f
);
  typedef enum logic [1:0] {RST, FETCH, HOLD} state_t;
  state_t state, state_nx;
  logic [31:0] pc, pc_nx, instr, instr_nx, pc4, pc4_nx;
  logic [31:0] buf_instr, buf_instr_nx, buf_pc4, buf_pc4_nx, pend_pc, pend_pc_nx;
  logic        valid, valid_nx, pend, pend_nx;
  logic [31:0] seq_pc, target;
  logic        go, redir;
  assign seq_pc = pc + 32'd4;
  assign go     = f.IF_ID_Flush & ~f.IF_ID_Stall;
  assign redir  = go & (f.PCSrc != 2'b00);
  assign target = f.PCSrc == 2'b01 ? f.Branch_Target :
                  f.PCSrc == 2'b10 ? {pc4[31:28], f.Jump_Index, 2'b00} : f.JR_Target;
  assign f.IMem_Req    = state == FETCH;
  assign f.IMem_Addr   = pc;
  assign f.Fetch_Busy  = f.IMem_Req & ~f.IMem_Ready;
  assign f.IF_ID_Instr = instr;
  assign f.IF_ID_PC4   = pc4;
  assign f.IF_ID_Valid = valid;
  always_comb begin
    state_nx     = state;
    pc_nx        = pc;
    instr_nx     = instr;
    pc4_nx       = pc4;
    valid_nx     = valid;
    buf_instr_nx = buf_instr;
    buf_pc4_nx   = buf_pc4;
    pend_nx      = pend;
    pend_pc_nx   = pend_pc;
    // an unstalled IF/ID takes a bubble unless a valid instruction is loaded below
    if (!f.IF_ID_Stall) begin
      instr_nx = '0;
      valid_nx = 1'b0;
    end
    case (state)
      RST: state_nx = FETCH;
      FETCH:
        if (f.IMem_Ready) begin
          if (pend) begin
            pend_nx = 1'b0;
            pc_nx   = redir ? target : pend_pc;
          end else if (redir) pc_nx = target;
          else if (go) pc_nx = f.PC_Stall ? pc : seq_pc;
          else if (f.IF_ID_Stall) begin
            buf_instr_nx = f.IMem_Data;
            buf_pc4_nx   = seq_pc;
            state_nx     = HOLD;
          end else begin
            instr_nx = f.IMem_Data;
            pc4_nx   = seq_pc;
            valid_nx = 1'b1;
            pc_nx    = f.PC_Stall ? pc : seq_pc;
          end
        end else if (redir) begin
          pend_nx    = 1'b1;
          pend_pc_nx = target;
        end
      HOLD:
        if (!f.IF_ID_Stall) begin
          state_nx = FETCH;
          pc_nx    = redir ? target : seq_pc;
          if (go) begin
            buf_instr_nx = '0;
            buf_pc4_nx   = '0;
          end else begin
            instr_nx = buf_instr;
            pc4_nx   = buf_pc4;
            valid_nx = 1'b1;
          end
        end
      default: state_nx = RST;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= RST;
      pc        <= RESET_PC;
      instr     <= '0;
      pc4       <= '0;
      valid     <= 1'b0;
      buf_instr <= '0;
      buf_pc4   <= '0;
      pend      <= 1'b0;
      pend_pc   <= '0;
    end else begin
      state     <= state_nx;
      pc        <= pc_nx;
      instr     <= instr_nx;
      pc4       <= pc4_nx;
      valid     <= valid_nx;
      buf_instr <= buf_instr_nx;
      buf_pc4   <= buf_pc4_nx;
      pend      <= pend_nx;
      pend_pc   <= pend_pc_nx;
    end
`ifdef IF_FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      Stall_Cycles <= '0;
      Flush_Count  <= '0;
    end else begin
      Stall_Cycles <= Stall_Cycles + {31'd0, f.IF_ID_Stall};
      Flush_Count  <= Flush_Count + {31'd0, go};
    end
`else
`endif
endmodule
